// File: rtl/norm_lut_addr_gen.sv
// rtl/norm_lut_addr_gen.sv - normalization LUT address generator and scaler
//
// Purpose: takes a stream of signed activations, sums the squares of the last
// WINDOW samples of the current group, and turns that sum into a saturated
// address for an external registered LUT ROM. One cycle after the read, the
// LUT value is used to scale the activation in fixed point.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous reset, active low
//   in_data      signed activation            in_valid / in_ready / in_last
//   rom_address  registered ROM address       rom_enable (read strobe)
//   rom_data     ROM registered output, unsigned, FRAC_BITS fractional bits
//   out_data     saturated scaled activation  out_valid / out_ready / out_last
module norm_lut_addr_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int LUT_WIDTH  = 16,
  parameter int WINDOW     = 3,
  parameter int SQ_SHIFT   = 8,
  parameter int FRAC_BITS  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_enable,
  input  logic [LUT_WIDTH-1:0]  rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int SQ_W   = 2 * DATA_WIDTH;
  localparam int SUM_W  = 2 * DATA_WIDTH + $clog2(WINDOW) + 1;
  localparam int HIST_N = (WINDOW > 1) ? WINDOW - 1 : 1;
  localparam int PROD_W = DATA_WIDTH + LUT_WIDTH + 1;

  logic                  adv;
  logic                  accept;
  logic [SQ_W-1:0]       sq;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      sum_shr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [SQ_W-1:0]       hist [HIST_N];

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_x;
  logic                  s1_last;
  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_x;
  logic                  s2_last;

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_shr;
  logic [DATA_WIDTH-1:0]    sat_data;

  // The whole pipeline moves as one: it only freezes when the output register
  // holds data the consumer has not taken.
  assign adv        = !out_valid || out_ready;
  assign in_ready   = reset && adv;
  assign accept     = in_valid && in_ready;
  // Reading only on advance keeps rom_data aligned with S2 across stalls.
  assign rom_enable = reset && s1_valid && adv;

  // Square of a two's complement value is never negative and fits in 2*DW
  // bits, including the -2^(DW-1) corner.
  assign sq = $signed(in_data) * $signed(in_data);

  always_comb begin
    sum = SUM_W'(sq);
    for (int i = 0; i < WINDOW - 1; i++) begin
      sum = sum + SUM_W'(hist[i]);
    end
    sum_shr = sum >> SQ_SHIFT;
    if (sum_shr > {{(SUM_W - ADDR_WIDTH){1'b0}}, {ADDR_WIDTH{1'b1}}}) begin
      addr = '1;
    end else begin
      addr = sum_shr[ADDR_WIDTH-1:0];
    end
  end

  // LUT value is unsigned, so it gets a zero sign bit before the signed
  // multiply; >>> floors toward -inf.
  assign prod     = $signed(s2_x) * $signed({1'b0, rom_data});
  assign prod_shr = prod >>> FRAC_BITS;

  always_comb begin
    sat_data = prod_shr[DATA_WIDTH-1:0];
    if (prod_shr[PROD_W-1:DATA_WIDTH-1] !=
        {(PROD_W - DATA_WIDTH + 1){prod_shr[PROD_W-1]}}) begin
      sat_data = prod_shr[PROD_W-1] ? {1'b1, {(DATA_WIDTH - 1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < HIST_N; i++) begin
        hist[i] <= '0;
      end
      rom_address <= '0;
      s1_valid    <= 1'b0;
      s1_x        <= '0;
      s1_last     <= 1'b0;
      s2_valid    <= 1'b0;
      s2_x        <= '0;
      s2_last     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
    end else begin
      // A group's last sample wipes the history so the next group starts clean.
      if (accept) begin
        if (in_last) begin
          for (int i = 0; i < HIST_N; i++) begin
            hist[i] <= '0;
          end
        end else begin
          hist[0] <= sq;
          for (int i = 1; i < HIST_N; i++) begin
            hist[i] <= hist[i-1];
          end
        end
      end
      if (adv) begin
        s1_valid <= accept;
        if (accept) begin
          rom_address <= addr;
          s1_x        <= in_data;
          s1_last     <= in_last;
        end
        s2_valid  <= s1_valid;
        s2_x      <= s1_x;
        s2_last   <= s1_last;
        out_valid <= s2_valid;
        out_data  <= sat_data;
        out_last  <= s2_last;
      end
    end
  end

endmodule

// File: doc/norm_lut_addr_gen.md
# norm_lut_addr_gen

Normalization front/back end that wraps the normalization LUT ROM. Accepts a stream of signed activations, computes a windowed sum of squares per sample, and converts it into a saturated LUT address for the ROM. It drives the ROM's `address`/`enable`, takes the registered LUT value one cycle later, and emits each activation multiplied by its fixed-point LUT scale. Sits between the activation stream and the normalization output buffer; the ROM instance is external and attached via the `rom_*` ports.

## Interface
- `DATA_WIDTH`, 16: signed activation width, input and output.
- `ADDR_WIDTH`, 11: ROM address width.
- `LUT_WIDTH`, 16: unsigned ROM data width.
- `WINDOW`, 3: number of trailing squares summed, current sample included; ≥1.
- `SQ_SHIFT`, 8: right shift applied to the sum of squares before address saturation.
- `FRAC_BITS`, 14: fractional bits of the LUT value (0x4000 = 1.0 at 14).

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `in_data`  in  DATA_WIDTH  signed activation.
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  final sample of a normalization group.
- `in_ready`  out  1  block accepts input this cycle.
- `rom_address`  out  ADDR_WIDTH  ROM address (registered).
- `rom_enable`  out  1  ROM read enable.
- `rom_data`  in  LUT_WIDTH  ROM registered output.
- `out_data`  out  DATA_WIDTH  normalized signed result (registered).
- `out_valid`  out  1  `out_data` valid.
- `out_last`  out  1  accompanies the output of an `in_last` sample.
- `out_ready`  in  1  downstream accepts output.

## Operation
- Global advance: `adv = !out_valid | out_ready`. `in_ready = adv` while `reset` is high, 0 while `reset` is low. Accept when `in_valid & in_ready`.
- Stage S1, on accept:
  - square `sq = in_data*in_data`, unsigned 2*DATA_WIDTH.
  - `sum = sq + ` squares of the previous WINDOW-1 accepted samples in the same group; width 2*DATA_WIDTH+clog2(WINDOW)+1, no overflow.
  - `addr = min(sum >> SQ_SHIFT, 2^ADDR_WIDTH-1)`.
  - Register `rom_address<=addr`, x, last, `s1_valid<=1`.
  - If `adv` with no accept, `s1_valid<=0`.
- Square history shift register, WINDOW-1 entries:
  - Shifts in `sq` on each accept.
  - Accept with `in_last=1` clears all entries to 0 after use, so the next sample starts a fresh group.
  - Samples before the first group after reset count as 0.
- ROM read: `rom_enable = s1_valid & adv` (combinational). When stalled, `rom_enable=0`, so the ROM holds its output.
- Stage S2, on `adv`: `s2_valid<=s1_valid`; x and last move from S1 to S2. `rom_data` is valid in the cycle after S2 loads.
- Output, on `adv`:
  - `out_valid<=s2_valid`.
  - `prod = $signed(x)*$signed({1'b0,rom_data})`, width DATA_WIDTH+LUT_WIDTH+1.
  - `out_data<=sat(prod >>> FRAC_BITS)`: arithmetic shift, truncation toward -inf, saturate to [-2^(DW-1), 2^(DW-1)-1].
  - `out_last<=s2_last`.
- Handshake: `out_data`/`out_valid`/`out_last` hold stable while `out_valid & !out_ready`. No sample is dropped or duplicated, and order is preserved.
- Reset asserted, any time:
  - all valids, history, `rom_address`, `out_data` and `out_last` go to 0 immediately; in-flight samples are discarded.
  - `rom_enable=0`, `in_ready=0`.

## Timing
- Reset values: `rom_address=0`, `rom_enable=0`, `out_data=0`, `out_valid=0`, `out_last=0`, `in_ready=0`. `in_ready=1` from the first cycle after deassert.
- Latency: sample accepted in cycle T has `rom_enable=1` in T+1, `rom_data` valid in T+2, and `out_valid=1` in T+3 (no stall).
- Throughput: 1 sample/cycle with `out_ready` held high.
- Stall: `out_ready=0` with `out_valid=1` freezes S1, S2 and the output in the same cycle; `in_ready` and `rom_enable` drop combinationally.
- Simultaneous `out_ready` and new accept in the same cycle: the output is consumed and the pipeline advances, with no bubble.

## Test plan
- Bench ROM `mem[a]=0x4000`; `in_data=16`, `in_last=1` -> `rom_address=1`, `rom_enable` pulse at T+1, `out_data=16`, `out_last=1` at T+3.
- Group 10,20,30,40 (last on 40), constant ROM -> `rom_address` sequence 0,1,5,11; outputs 10,20,30,40 on consecutive cycles; `out_last` only on 40.
- `in_data=-32768` -> `rom_address=2047`; with ROM 0x4000 -> `out_data=-32768`. `in_data=32767` with ROM 0xFFFF -> `out_data=32767` (saturated).
- 8-sample stream, `out_ready` low for 5 cycles mid-stream -> `in_ready=0` and `rom_enable=0` during the stall; all 8 outputs delivered in order with correct values.
- Group boundary: 100 (last), then 1 -> second address `1>>8=0`, unaffected by the 10000 square.
- `reset` pulsed low with 3 samples in flight -> outputs 0 immediately, none of the 3 emerge; next sample after release uses an empty history.
